// File: rtl/sfifo_wr_arb.sv
// Round-robin write arbiter: shares one sfifo write port among NREQ producers,
// granting one owner at a time for up to MAXBURST stores, with a one-cycle idle bubble.
module sfifo_wr_arb #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata_in,
  input  logic                  fifo_full,
  output logic                  fifo_store,
  output logic [WIDTH-1:0]      fifo_wdata,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, rr, pick;
  logic            found;
  logic [7:0]      count;
  logic [WIDTH-1:0] owner_data;
  logic            own_req, last_word, release_now;

  // First requester at or above rr, wrapping around.
  always_comb begin
    int k;
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(rr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && req[IW'(k)]) begin
        found = 1'b1;
        pick  = IW'(k);
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IW'(i)) owner_data = wdata_in[i*WIDTH +: WIDTH];
    end
  end

  assign own_req     = (state == OWN) && req[owner];
  assign fifo_store  = own_req && !fifo_full;
  assign ack         = fifo_store ? grant : '0;
  assign fifo_wdata  = (state == OWN) ? owner_data : '0;
  assign busy        = (state == OWN);
  assign last_word   = fifo_store && (count == 8'(MAXBURST - 1));
  // A dropped request releases even while the fifo is full.
  assign release_now = (state == OWN) && (!req[owner] || last_word);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = OWN;
      OWN:     if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      rr    <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            grant <= NREQ'(1) << pick;
            count <= '0;
          end
        end
        OWN: begin
          if (release_now) begin
            grant <= '0;
            rr    <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
          end else if (fifo_store) begin
            count <= count + 8'd1;
          end
        end
        default: grant <= '0;
      endcase
    end
  end

endmodule
